fir_mc_serial: RTL

Parametrised, time-multiplexed serial-MAC FIR filter. It serves Channels independent sample streams with one shared multiplier, one shared coefficient set and per-channel delay lines. It is the next-generation filter core in the DSP chain, with a configurable tap count, runtime-loadable coefficients, a ready/valid input handshake and a channel-tagged output.

---
 rtl/fir_mc_serial_pkg.sv | 22 ++
 rtl/fir_mc_serial_if.sv | 37 +++
 rtl/fir_mc_serial_ctrl.sv | 120 ++++++++++++
 rtl/fir_mc_serial.sv | 113 +++++++++++
 4 files changed

// File: rtl/fir_mc_serial_pkg.sv
// rtl/fir_mc_serial_pkg.sv - shared FSM encoding and width helpers for the serial-MAC FIR
package fir_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int addr_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int out_w(input int iw, input int cw, input int taps);
    return iw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mc_serial_if.sv
// rtl/fir_mc_serial_if.sv - sample, coefficient and result signals of the serial-MAC FIR
interface fir_mc_serial_if
  import fir_mc_pkg::*;
#(
  parameter int InputWidth  = 16,
  parameter int CoeffWidth  = 16,
  parameter int Taps        = 64,
  parameter int Channels    = 2,
  parameter int OutputWidth = out_w(InputWidth, CoeffWidth, Taps)
);
  localparam int ChW = ch_w(Channels);
  localparam int AW  = addr_w(Taps);

  logic                          inputValid;
  logic                          inputReady;
  logic signed [InputWidth-1:0]  FIR_input;
  logic        [ChW-1:0]         in_ch;
  logic                          clear;
  logic                          coef_we;
  logic        [AW-1:0]          coef_addr;
  logic signed [CoeffWidth-1:0]  coef_data;
  logic                          outputValid;
  logic signed [OutputWidth-1:0] FIR_output;
  logic        [ChW-1:0]         out_ch;
  logic                          ch_err;

  modport master (
    output inputValid, FIR_input, in_ch, clear, coef_we, coef_addr, coef_data,
    input  inputReady, outputValid, FIR_output, out_ch, ch_err
  );

  modport slave (
    input  inputValid, FIR_input, in_ch, clear, coef_we, coef_addr, coef_data,
    output inputReady, outputValid, FIR_output, out_ch, ch_err
  );

endinterface

// File: rtl/fir_mc_serial_ctrl.sv
// rtl/fir_mc_serial_ctrl.sv - FSM, tap counter and per-channel write pointers of the serial-MAC FIR
module fir_mc_ctrl
  import fir_mc_pkg::*;
#(
  parameter int Taps     = 64,
  parameter int Channels = 2,
  parameter int ChW      = ch_w(Channels),
  parameter int AW       = addr_w(Taps)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  input  logic [ChW-1:0] i_in_ch,
  input  logic           i_clear,
  output logic           o_ready,
  output logic           o_wr_en,
  output logic [ChW-1:0] o_wr_ch,
  output logic [AW-1:0]  o_wr_idx,
  output logic           o_clear_all,
  output logic           o_mac,
  output logic           o_last,
  output logic [AW-1:0]  o_k,
  output logic [AW-1:0]  o_rd_idx,
  output logic [ChW-1:0] o_ch,
  output logic           o_out_valid,
  output logic [ChW-1:0] o_out_ch,
  output logic           o_ch_err
);

  localparam logic [AW-1:0] LastTap = AW'(Taps - 1);

  state_t         r_state;
  logic [AW-1:0]  r_k;
  logic [AW-1:0]  r_rd_idx;
  logic [ChW-1:0] r_ch;
  logic [ChW-1:0] r_out_ch;
  logic           r_out_valid;
  logic           r_ch_err;
  logic [AW-1:0]  r_wptr [Channels];

  logic           w_legal;
  logic           w_accept;
  logic [ChW-1:0] w_in_ch_safe;

  // A channel field that exactly fills its encoding can never be illegal.
  generate
    if ((1 << ChW) == Channels) begin : g_ch_full
      assign w_legal = 1'b1;
    end else begin : g_ch_part
      assign w_legal = (int'(i_in_ch) < Channels);
    end
  endgenerate

  assign o_ready      = (r_state == IDLE) && !i_clear && !i_rst;
  assign w_accept     = o_ready && i_valid;
  assign w_in_ch_safe = w_legal ? i_in_ch : '0;
  assign o_wr_en      = w_accept && w_legal;
  assign o_wr_ch      = w_in_ch_safe;
  assign o_wr_idx     = r_wptr[w_in_ch_safe];
  assign o_clear_all  = i_clear && (r_state != MAC);
  assign o_mac        = (r_state == MAC);
  assign o_last       = o_mac && (r_k == LastTap);
  assign o_k          = r_k;
  assign o_rd_idx     = r_rd_idx;
  assign o_ch         = r_ch;
  assign o_out_valid  = r_out_valid;
  assign o_out_ch     = r_out_ch;
  assign o_ch_err     = r_ch_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_rd_idx    <= '0;
      r_ch        <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ch_err    <= 1'b0;
      for (int c = 0; c < Channels; c++) r_wptr[c] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_ch_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (o_clear_all) begin
            for (int c = 0; c < Channels; c++) r_wptr[c] <= '0;
          end else if (w_accept) begin
            if (w_legal) begin
              r_ch     <= i_in_ch;
              r_k      <= '0;
              r_rd_idx <= r_wptr[w_in_ch_safe];
              r_state  <= MAC;
            end else begin
              r_ch_err <= 1'b1;
            end
          end
        end
        MAC: begin
          // Walk the history backwards from the newest sample.
          r_k      <= r_k + 1'b1;
          r_rd_idx <= (r_rd_idx == '0) ? LastTap : r_rd_idx - 1'b1;
          if (r_k == LastTap) begin
            r_state      <= OUT;
            r_out_valid  <= 1'b1;
            r_out_ch     <= r_ch;
            r_wptr[r_ch] <= (r_wptr[r_ch] == LastTap) ? '0 : r_wptr[r_ch] + 1'b1;
          end
        end
        OUT: begin
          if (i_clear) begin
            for (int c = 0; c < Channels; c++) r_wptr[c] <= '0;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fir_mc_serial.sv
// rtl/fir_mc_serial.sv - multichannel FIR sharing one multiplier, one coefficient set, per-channel histories
module fir_mc_serial
  import fir_mc_pkg::*;
#(
  parameter int InputWidth  = 16,
  parameter int CoeffWidth  = 16,
  parameter int Taps        = 64,
  parameter int Channels    = 2,
  parameter int OutputWidth = out_w(InputWidth, CoeffWidth, Taps)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fir_mc_serial_if.slave bus
);

  localparam int ChW = ch_w(Channels);
  localparam int AW  = addr_w(Taps);
  localparam int PW  = InputWidth + CoeffWidth;

  logic signed [CoeffWidth-1:0]  r_coef  [Taps];
  logic signed [InputWidth-1:0]  r_delay [Channels][Taps];
  logic signed [OutputWidth-1:0] r_acc;
  logic signed [OutputWidth-1:0] r_out;

  logic           w_ready;
  logic           w_wr_en;
  logic [ChW-1:0] w_wr_ch;
  logic [AW-1:0]  w_wr_idx;
  logic           w_clear_all;
  logic           w_mac;
  logic           w_last;
  logic [AW-1:0]  w_k;
  logic [AW-1:0]  w_rd_idx;
  logic [ChW-1:0] w_ch;
  logic           w_out_valid;
  logic [ChW-1:0] w_out_ch;
  logic           w_ch_err;
  logic           w_addr_ok;

  logic signed [CoeffWidth-1:0]  w_coef_k;
  logic signed [InputWidth-1:0]  w_tap;
  logic signed [PW-1:0]          w_prod;
  logic signed [OutputWidth-1:0] w_sum;

  fir_mc_ctrl #(
    .Taps     (Taps),
    .Channels (Channels)
  ) u_ctrl (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (bus.inputValid),
    .i_in_ch     (bus.in_ch),
    .i_clear     (bus.clear),
    .o_ready     (w_ready),
    .o_wr_en     (w_wr_en),
    .o_wr_ch     (w_wr_ch),
    .o_wr_idx    (w_wr_idx),
    .o_clear_all (w_clear_all),
    .o_mac       (w_mac),
    .o_last      (w_last),
    .o_k         (w_k),
    .o_rd_idx    (w_rd_idx),
    .o_ch        (w_ch),
    .o_out_valid (w_out_valid),
    .o_out_ch    (w_out_ch),
    .o_ch_err    (w_ch_err)
  );

  generate
    if ((1 << AW) == Taps) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_part
      assign w_addr_ok = (int'(bus.coef_addr) < Taps);
    end
  endgenerate

  assign w_coef_k = r_coef[w_k];
  assign w_tap    = r_delay[w_ch][w_rd_idx];
  assign w_prod   = $signed({{InputWidth{w_coef_k[CoeffWidth-1]}}, w_coef_k}) *
                    $signed({{CoeffWidth{w_tap[InputWidth-1]}}, w_tap});
  assign w_sum    = r_acc + {{(OutputWidth - PW){w_prod[PW-1]}}, w_prod};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < Taps; k++) r_coef[k] <= '0;
      for (int c = 0; c < Channels; c++) begin
        for (int t = 0; t < Taps; t++) r_delay[c][t] <= '0;
      end
      r_acc <= '0;
      r_out <= '0;
    end else begin
      // Coefficients stay frozen while a sum is being built.
      if (bus.coef_we && !w_mac && w_addr_ok) r_coef[bus.coef_addr] <= bus.coef_data;
      if (w_clear_all) begin
        for (int c = 0; c < Channels; c++) begin
          for (int t = 0; t < Taps; t++) r_delay[c][t] <= '0;
        end
      end else if (w_wr_en) begin
        r_delay[w_wr_ch][w_wr_idx] <= bus.FIR_input;
      end
      if (w_wr_en) r_acc <= '0;
      else if (w_mac) r_acc <= w_sum;
      if (w_last) r_out <= w_sum;
    end
  end

  assign bus.inputReady  = w_ready;
  assign bus.outputValid = w_out_valid;
  assign bus.FIR_output  = r_out;
  assign bus.out_ch      = w_out_ch;
  assign bus.ch_err      = w_ch_err;

endmodule
